// File: rtl/branch_resolve_bht_pkg.sv
// Shared MIPS branch definitions: opcode/rt encodings and BHT counter type.
package branch_defs;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    // 2-bit saturating counter; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    // Saturating step toward the resolved direction
    function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
        bht_ctr_t n;
        n = c;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = WNT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_resolve_bht_cond.sv
// Branch decode and condition evaluation for conditional MIPS branches.
module br_cond
    import branch_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        op,
    input  logic [4:0]        rt,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              is_branch,
    output logic              cond,
    output logic              is_link
);

    logic s;
    logic z;

    assign s = a[DATA_W-1];
    assign z = (a == '0);

    // Decode opcode / REGIMM sub-opcode and evaluate the branch condition
    always_comb begin
        is_branch = 1'b0;
        cond      = 1'b0;
        is_link   = 1'b0;
        case (op)
            OP_BEQ: begin
                is_branch = 1'b1;
                cond      = (a == b);
            end
            OP_BNE: begin
                is_branch = 1'b1;
                cond      = (a != b);
            end
            OP_BLEZ: begin
                is_branch = 1'b1;
                cond      = s || z;
            end
            OP_BGTZ: begin
                is_branch = 1'b1;
                cond      = !s && !z;
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ: begin
                        is_branch = 1'b1;
                        cond      = s;
                    end
                    RT_BGEZ: begin
                        is_branch = 1'b1;
                        cond      = !s;
                    end
                    RT_BLTZAL: begin
                        is_branch = 1'b1;
                        cond      = s;
                        is_link   = 1'b1;
                    end
                    RT_BGEZAL: begin
                        is_branch = 1'b1;
                        cond      = !s;
                        is_link   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolution unit: registered outcome/mispredict, 2-bit BHT, statistics.
module branch_resolve_bht
    import branch_defs::*;
#(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_W     = $clog2(BHT_DEPTH),
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_i,
    input  logic [31:0]       pc_i,
    input  logic [5:0]        op_i,
    input  logic [4:0]        rt_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              pred_taken_i,
    input  logic [31:0]       fetch_pc_i,
    output logic              pred_taken_o,
    output logic              res_valid_o,
    output logic              res_taken_o,
    output logic              res_link_o,
    output logic              mispredict_o,
    output logic [STAT_W-1:0] br_count_o,
    output logic [STAT_W-1:0] mispred_count_o
);

    logic             is_branch;
    logic             cond;
    logic             is_link;
    logic             acc;
    logic             mispred;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] fetch_idx;
    bht_ctr_t         fetch_ctr;
    bht_ctr_t         bht [BHT_DEPTH];
    logic             unused_pc_bits;

    br_cond #(
        .DATA_W (DATA_W)
    ) u_cond (
        .op        (op_i),
        .rt        (rt_i),
        .a         (a_i),
        .b         (b_i),
        .is_branch (is_branch),
        .cond      (cond),
        .is_link   (is_link)
    );

    assign acc       = valid_i && is_branch && !stall && !flush;
    assign mispred   = (cond != pred_taken_i);
    assign upd_idx   = pc_i[IDX_W+1:2];
    assign fetch_idx = fetch_pc_i[IDX_W+1:2];

    // Fetch reads the array state before this edge's update (no bypass)
    assign fetch_ctr    = bht[fetch_idx];
    assign pred_taken_o = fetch_ctr[1];

    assign unused_pc_bits = ^{pc_i[31:IDX_W+2], pc_i[1:0],
                              fetch_pc_i[31:IDX_W+2], fetch_pc_i[1:0]};

    // Result registers: hold on stall, capture on accept, otherwise clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_o  <= 1'b0;
            res_taken_o  <= 1'b0;
            res_link_o   <= 1'b0;
            mispredict_o <= 1'b0;
        end else if (!stall) begin
            if (acc) begin
                res_valid_o  <= 1'b1;
                res_taken_o  <= cond;
                res_link_o   <= is_link;
                mispredict_o <= mispred;
            end else begin
                res_valid_o  <= 1'b0;
                res_taken_o  <= 1'b0;
                res_link_o   <= 1'b0;
                mispredict_o <= 1'b0;
            end
        end
    end

    // BHT: every entry weakly not-taken on reset, saturating train on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= WNT;
            end
        end else if (acc) begin
            bht[upd_idx] <= ctr_next(bht[upd_idx], cond);
        end
    end

    // Saturating branch and mispredict statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_o      <= '0;
            mispred_count_o <= '0;
        end else if (acc) begin
            if (br_count_o != '1) begin
                br_count_o <= br_count_o + 1'b1;
            end
            if (mispred && (mispred_count_o != '1)) begin
                mispred_count_o <= mispred_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Self-checking bench for branch_resolve_bht with a behavioural reference model.
module tb_branch_resolve_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, valid, pred_in;
    logic [31:0] pc, fetch_pc, a, b;
    logic [5:0]  op;
    logic [4:0]  rt;

    logic        p1, v1, t1, l1, m1;
    logic [15:0] br1, mp1;
    logic        p2, v2, t2, l2, m2;
    logic [3:0]  br2, mp2;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int   m_bht1 [64];
    int   m_bht2 [2];
    int   m_br1, m_mp1, m_br2, m_mp2;
    logic m_v, m_t, m_l, m_m;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [31:0] a;
        logic [3:0]  flags;
    } vec_t;

    always #5 clk = ~clk;

    branch_resolve_bht #(.DATA_W(32), .BHT_DEPTH(64), .STAT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_i(valid),
        .pc_i(pc), .op_i(op), .rt_i(rt), .a_i(a), .b_i(b), .pred_taken_i(pred_in),
        .fetch_pc_i(fetch_pc), .pred_taken_o(p1), .res_valid_o(v1), .res_taken_o(t1),
        .res_link_o(l1), .mispredict_o(m1), .br_count_o(br1), .mispred_count_o(mp1)
    );

    branch_resolve_bht #(.DATA_W(32), .BHT_DEPTH(2), .STAT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_i(valid),
        .pc_i(pc), .op_i(op), .rt_i(rt), .a_i(a), .b_i(b), .pred_taken_i(pred_in),
        .fetch_pc_i(fetch_pc), .pred_taken_o(p2), .res_valid_o(v2), .res_taken_o(t2),
        .res_link_o(l2), .mispredict_o(m2), .br_count_o(br2), .mispred_count_o(mp2)
    );

    // Architectural branch semantics from signed arithmetic on the operand
    function automatic void ref_eval(input logic [5:0] o, input logic [4:0] r,
                                     input logic [31:0] x, input logic [31:0] y,
                                     output logic br, output logic c, output logic lk);
        br = 1'b0; c = 1'b0; lk = 1'b0;
        case (int'(o))
            4: begin br = 1'b1; c = (x == y); end
            5: begin br = 1'b1; c = (x != y); end
            6: begin br = 1'b1; c = ($signed(x) <= 0); end
            7: begin br = 1'b1; c = ($signed(x) > 0); end
            1: if (r == 5'd0 || r == 5'd1 || r == 5'd16 || r == 5'd17) begin
                   br = 1'b1;
                   c  = r[0] ? ($signed(x) >= 0) : ($signed(x) < 0);
                   lk = (r >= 5'd16);
               end
            default: ;
        endcase
    endfunction

    task automatic model_reset();
        foreach (m_bht1[i]) m_bht1[i] = 1;
        foreach (m_bht2[i]) m_bht2[i] = 1;
        m_br1 = 0; m_mp1 = 0; m_br2 = 0; m_mp2 = 0;
        m_v = 0; m_t = 0; m_l = 0; m_m = 0;
    endtask

    // Advance one clock and apply the same edge to the model
    task automatic tick();
        logic br, c, lk;
        int   i1, i2;
        ref_eval(op, rt, a, b, br, c, lk);
        i1 = int'(pc[7:2]);
        i2 = int'(pc[2]);
        @(posedge clk);
        if (!stall) begin
            if (valid && br && !flush) begin
                m_v = 1'b1; m_t = c; m_l = lk; m_m = (c != pred_in);
                m_bht1[i1] = c ? ((m_bht1[i1] < 3) ? m_bht1[i1] + 1 : 3)
                               : ((m_bht1[i1] > 0) ? m_bht1[i1] - 1 : 0);
                m_bht2[i2] = c ? ((m_bht2[i2] < 3) ? m_bht2[i2] + 1 : 3)
                               : ((m_bht2[i2] > 0) ? m_bht2[i2] - 1 : 0);
                if (m_br1 < 65535) m_br1++;
                if (m_br2 < 15) m_br2++;
                if (c != pred_in) begin
                    if (m_mp1 < 65535) m_mp1++;
                    if (m_mp2 < 15) m_mp2++;
                end
            end else begin
                m_v = 1'b0; m_t = 1'b0; m_l = 1'b0; m_m = 1'b0;
            end
        end
        #1;
    endtask

    task automatic set_in(input logic [5:0] o, input logic [4:0] r, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] p, input logic pr);
        valid = 1'b1; op = o; rt = r; a = x; b = y; pc = p; pred_in = pr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; flush = 0; valid = 0; op = 0; rt = 0;
        a = 0; b = 0; pc = 0; pred_in = 0; fetch_pc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({v1, t1, l1, m1, br1, mp1} !== 36'h0) begin
            n_bad++; $display("FAIL reset_dut1: got %h want 0", {v1, t1, l1, m1, br1, mp1});
        end
        n_cmp++;
        if ({v2, t2, l2, m2, br2, mp2} !== 12'h0) begin
            n_bad++; $display("FAIL reset_dut2: got %h want 0", {v2, t2, l2, m2, br2, mp2});
        end
        for (int i = 0; i < 4; i++) begin
            fetch_pc = 32'h100 + 32'(i * 4);
            #1;
            n_cmp++;
            if ({p1, p2} !== 2'b00) begin
                n_bad++; $display("FAIL reset_pred pc=%h: got %b want 00", fetch_pc, {p1, p2});
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_beq_first();
        set_in(6'b000100, 5'd0, 32'h5, 32'h5, 32'h100, 1'b0);
        fetch_pc = 32'h100;
        tick();
        n_cmp++;
        if ({v1, t1, l1, m1, br1, mp1} !== {4'b1101, 16'd1, 16'd1}) begin
            n_bad++; $display("FAIL beq_first: got %b/%0d/%0d want 1101/1/1", {v1, t1, l1, m1}, br1, mp1);
        end
        valid = 1'b0;
        #1;
        n_cmp++;
        if (p1 !== 1'b1) begin
            n_bad++; $display("FAIL beq_first_pred: got %b want 1", p1);
        end
        tick();
    endtask

    task automatic test_sign_zero();
        vec_t tab[7];
        tab[0] = '{6'b000111, 5'd0,  32'h0000_0000, 4'b1000};
        tab[1] = '{6'b000110, 5'd0,  32'h8000_0000, 4'b1101};
        tab[2] = '{6'b000001, 5'd1,  32'h0000_0000, 4'b1101};
        tab[3] = '{6'b000001, 5'd16, 32'hFFFF_FFFF, 4'b1111};
        tab[4] = '{6'b000001, 5'd2,  32'h8000_0000, 4'b0000};
        tab[5] = '{6'b000001, 5'd17, 32'h8000_0000, 4'b1010};
        tab[6] = '{6'b000001, 5'd0,  32'h0000_0001, 4'b1000};
        for (int i = 0; i < 7; i++) begin
            set_in(tab[i].op, tab[i].rt, tab[i].a, 32'h1234, 32'h80 + 32'(i * 4), 1'b0);
            fetch_pc = pc;
            tick();
            n_cmp++;
            if ({v1, t1, l1, m1} !== tab[i].flags) begin
                n_bad++; $display("FAIL sign_zero[%0d]: got %b want %b", i, {v1, t1, l1, m1}, tab[i].flags);
            end
            n_cmp++;
            if ({br1, mp1, p1} !== {16'(m_br1), 16'(m_mp1), (m_bht1[pc[7:2]] >= 2)}) begin
                n_bad++; $display("FAIL sign_zero_state[%0d]: got %0d/%0d/%b want %0d/%0d/%b",
                                  i, br1, mp1, p1, m_br1, m_mp1, (m_bht1[pc[7:2]] >= 2));
            end
        end
    endtask

    task automatic test_saturation();
        logic [6:0] want;
        want = 7'b1111100;
        fetch_pc = 32'h2C0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) set_in(6'b000101, 5'd0, 32'h1, 32'h2, 32'h2C0, 1'b1);
            else       set_in(6'b000101, 5'd0, 32'h3, 32'h3, 32'h2C0, 1'b1);
            tick();
            n_cmp++;
            if (p1 !== want[6 - i] || p1 !== (m_bht1[48] >= 2)) begin
                n_bad++; $display("FAIL saturation[%0d]: got %b want %b", i, p1, want[6 - i]);
            end
        end
    endtask

    task automatic test_stall_flush();
        set_in(6'b000101, 5'd0, 32'h1, 32'h2, 32'h64, 1'b0);
        fetch_pc = 32'h60;
        tick();
        set_in(6'b000100, 5'd0, 32'h7, 32'h7, 32'h60, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) flush = 1'b1;
            tick();
            n_cmp++;
            if ({v1, t1, l1, m1, br1, mp1, p1} !== {4'b1101, 16'(m_br1), 16'(m_mp1), 1'b0}) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got %b/%0d/%0d/%b want 1101/%0d/%0d/0",
                                  i, {v1, t1, l1, m1}, br1, mp1, p1, m_br1, m_mp1);
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if ({v1, t1, l1, m1, br1, mp1, p1} !== {4'b0000, 16'(m_br1), 16'(m_mp1), 1'b0}) begin
            n_bad++; $display("FAIL flush: got %b/%0d/%0d/%b want 0000/%0d/%0d/0",
                              {v1, t1, l1, m1}, br1, mp1, p1, m_br1, m_mp1);
        end
        flush = 1'b0; valid = 1'b0;
        tick();
    endtask

    task automatic test_same_cycle();
        set_in(6'b000100, 5'd0, 32'h9, 32'h9, 32'h14, 1'b0);
        fetch_pc = 32'h14;
        #1;
        n_cmp++;
        if (p1 !== 1'b0) begin
            n_bad++; $display("FAIL same_cycle_old: got %b want 0", p1);
        end
        tick();
        valid = 1'b0;
        #1;
        n_cmp++;
        if (p1 !== 1'b1) begin
            n_bad++; $display("FAIL same_cycle_new: got %b want 1", p1);
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        logic [4:0] rts [5];
        ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd0};
        rts = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd0};
        for (int i = 0; i < 400; i++) begin
            op = ops[$urandom_range(0, 5)];
            if (op == 6'd0) op = 6'($urandom);
            rt = rts[$urandom_range(0, 4)];
            if ($urandom_range(0, 4) == 0) rt = 5'($urandom);
            case ($urandom_range(0, 3))
                0:       a = 32'h0;
                1:       a = 32'h8000_0000 | 32'($urandom_range(0, 3));
                default: a = $urandom;
            endcase
            b       = ($urandom_range(0, 2) == 0) ? a : $urandom;
            pc      = {$urandom, 2'b00} & 32'h0000_00FC;
            fetch_pc = ($urandom_range(0, 1) == 0) ? pc : ({$urandom, 2'b00} & 32'h0000_00FC);
            valid   = ($urandom_range(0, 3) != 0);
            stall   = ($urandom_range(0, 7) == 0);
            flush   = ($urandom_range(0, 7) == 0);
            pred_in = 1'($urandom);
            #1;
            n_cmp++;
            if ({p1, p2} !== {(m_bht1[fetch_pc[7:2]] >= 2), (m_bht2[fetch_pc[2]] >= 2)}) begin
                n_bad++; $display("FAIL rand_pred[%0d]: got %b%b want %b%b", i, p1, p2,
                                  (m_bht1[fetch_pc[7:2]] >= 2), (m_bht2[fetch_pc[2]] >= 2));
            end
            tick();
            n_cmp++;
            if ({v1, t1, l1, m1, br1, mp1} !== {m_v, m_t, m_l, m_m, 16'(m_br1), 16'(m_mp1)}) begin
                n_bad++; $display("FAIL rand_dut1[%0d]: got %b/%0d/%0d want %b/%0d/%0d", i,
                                  {v1, t1, l1, m1}, br1, mp1, {m_v, m_t, m_l, m_m}, m_br1, m_mp1);
            end
            n_cmp++;
            if ({v2, t2, l2, m2, br2, mp2} !== {m_v, m_t, m_l, m_m, 4'(m_br2), 4'(m_mp2)}) begin
                n_bad++; $display("FAIL rand_dut2[%0d]: got %b/%0d/%0d want %b/%0d/%0d", i,
                                  {v2, t2, l2, m2}, br2, mp2, {m_v, m_t, m_l, m_m}, m_br2, m_mp2);
            end
        end
        stall = 1'b0; flush = 1'b0; valid = 1'b0;
        tick();
    endtask

    task automatic test_stat_sat_and_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        tick();
        set_in(6'b000100, 5'd0, 32'hA, 32'hA, 32'h40, 1'b0);
        fetch_pc = 32'h40;
        repeat (17) tick();
        n_cmp++;
        if ({br2, mp2} !== 8'hFF) begin
            n_bad++; $display("FAIL stat_sat_dut2: got %h/%h want F/F", br2, mp2);
        end
        n_cmp++;
        if ({br1, mp1, p1, p2} !== {16'd17, 16'd17, 2'b11}) begin
            n_bad++; $display("FAIL stat_dut1: got %0d/%0d/%b%b want 17/17/11", br1, mp1, p1, p2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({v1, t1, l1, m1, br1, mp1, p1, v2, t2, l2, m2, br2, mp2, p2} !== 50'h0) begin
            n_bad++; $display("FAIL midstream_reset: got %h want 0",
                              {v1, t1, l1, m1, br1, mp1, p1, v2, t2, l2, m2, br2, mp2, p2});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid = 1'b0;
        tick();
        n_cmp++;
        if ({v1, br1, p1, v2, br2, p2} !== {m_v, 16'(m_br1), (m_bht1[16] >= 2), m_v, 4'(m_br2), (m_bht2[0] >= 2)}) begin
            n_bad++; $display("FAIL after_reset: got %b/%0d/%b %b/%0d/%b want 0/0/0 0/0/0",
                              v1, br1, p1, v2, br2, p2);
        end
    endtask

    initial begin
        test_reset();
        test_beq_first();
        test_sign_zero();
        test_saturation();
        test_stall_flush();
        test_same_cycle();
        test_random();
        test_stat_sat_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
